// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmit write port
// among NREQ byte-stream requesters. A grant is held for a whole packet.
// Writes are spaced by at least one idle cycle so TX_FULL always reflects
// the previous write before the next byte is accepted. An owner that stalls
// mid-packet loses its grant after HOLD_TIMEOUT counted idle cycles.
//
// Ports:
//   PCLK, PRESETN       clock, synchronous active-low reset
//   REQ_VALID/LAST/DATA per-requester byte stream (requester i at [i*BITWIDTH +: BITWIDTH])
//   REQ_READY           combinational accept strobe, one-hot or zero
//   TX_FULL             UART transmit FIFO full
//   WR_UART, W_DATA     registered write strobe and byte to the UART
//   GRANT_ID            current or most recent grant owner
//   BUSY                high while a grant is locked
//   TIMEOUT_ERR         one-cycle pulse when a grant is revoked by timeout
module uart_tx_arbiter #(
  parameter int unsigned BITWIDTH     = 8,
  parameter int unsigned NREQ         = 4,
  parameter int unsigned HOLD_TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESETN,
  input  logic [NREQ-1:0]          REQ_VALID,
  input  logic [NREQ-1:0]          REQ_LAST,
  input  logic [NREQ*BITWIDTH-1:0] REQ_DATA,
  output logic [NREQ-1:0]          REQ_READY,
  input  logic                     TX_FULL,
  output logic                     WR_UART,
  output logic [BITWIDTH-1:0]      W_DATA,
  output logic [$clog2(NREQ)-1:0]  GRANT_ID,
  output logic                     BUSY,
  output logic                     TIMEOUT_ERR
);

  localparam int unsigned GID_W = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(HOLD_TIMEOUT);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_LOCK = 1'b1
  } state_t;

  // Registered state
  state_t              r_state;
  logic [GID_W-1:0]    r_last_grant;
  logic [GID_W-1:0]    r_grant_id;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic                r_wr_uart;
  logic [BITWIDTH-1:0] r_w_data;
  logic                r_busy;
  logic                r_timeout_err;

  // Next-state values
  state_t              w_state_nxt;
  logic [GID_W-1:0]    w_last_grant_nxt;
  logic [GID_W-1:0]    w_grant_id_nxt;
  logic [CNT_W-1:0]    w_stall_cnt_nxt;
  logic                w_wr_uart_nxt;
  logic [BITWIDTH-1:0] w_w_data_nxt;
  logic                w_timeout_nxt;

  // Combinational helpers
  logic [BITWIDTH-1:0] w_req_byte [NREQ];
  logic                w_any_valid;
  logic                w_own_valid;
  logic                w_own_last;
  logic                w_accept;
  logic                w_stall;
  logic                w_stall_expired;
  logic [GID_W-1:0]    w_rr_pick;

  // Split the flat data bus into one byte per requester
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_req_byte[gi] = REQ_DATA[gi*BITWIDTH +: BITWIDTH];
  end

  // First valid requester after 'last', wrapping modulo NREQ
  function automatic logic [GID_W-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [GID_W-1:0] last);
    logic [GID_W-1:0] pick;
    logic             found;
    int unsigned      idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last) + k) % NREQ;
      if (!found && valid[GID_W'(idx)]) begin
        found = 1'b1;
        pick  = GID_W'(idx);
      end
    end
    return pick;
  endfunction

  assign w_any_valid = |REQ_VALID;
  assign w_rr_pick   = rr_pick(REQ_VALID, r_last_grant);
  assign w_own_valid = REQ_VALID[r_grant_id];
  assign w_own_last  = REQ_LAST[r_grant_id];

  // Accept only when the FIFO has room and the previous write has settled;
  // held off during reset so no byte is consumed on the reset cycle
  assign w_accept = PRESETN && (r_state == S_LOCK) && w_own_valid &&
                    !TX_FULL && !r_wr_uart;

  // Only genuine owner idleness counts toward the timeout
  assign w_stall         = (r_state == S_LOCK) && !w_own_valid &&
                           !TX_FULL && !r_wr_uart;
  assign w_stall_expired = (r_stall_cnt == CNT_W'(HOLD_TIMEOUT - 1));

  assign REQ_READY = w_accept ? (NREQ'(1) << r_grant_id) : '0;

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_id_nxt   = r_grant_id;
    w_stall_cnt_nxt  = r_stall_cnt;
    w_wr_uart_nxt    = 1'b0;
    w_w_data_nxt     = r_w_data;
    w_timeout_nxt    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_grant_id_nxt  = w_rr_pick;
          w_stall_cnt_nxt = '0;
          w_state_nxt     = S_LOCK;
        end
      end

      S_LOCK: begin
        if (w_accept) begin
          w_wr_uart_nxt   = 1'b1;
          w_w_data_nxt    = w_req_byte[r_grant_id];
          w_stall_cnt_nxt = '0;
          if (w_own_last) begin
            w_last_grant_nxt = r_grant_id;
            w_state_nxt      = S_IDLE;
          end
        end else if (w_stall) begin
          if (w_stall_expired) begin
            w_timeout_nxt    = 1'b1;
            w_last_grant_nxt = r_grant_id;
            w_stall_cnt_nxt  = '0;
            w_state_nxt      = S_IDLE;
          end else begin
            w_stall_cnt_nxt = r_stall_cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_state       <= S_IDLE;
      r_last_grant  <= GID_W'(NREQ - 1);
      r_grant_id    <= '0;
      r_stall_cnt   <= '0;
      r_wr_uart     <= 1'b0;
      r_w_data      <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_wr_uart     <= w_wr_uart_nxt;
      r_w_data      <= w_w_data_nxt;
      r_busy        <= (w_state_nxt == S_LOCK);
      r_timeout_err <= w_timeout_nxt;
    end
  end

  assign WR_UART     = r_wr_uart;
  assign W_DATA      = r_w_data;
  assign GRANT_ID    = r_grant_id;
  assign BUSY        = r_busy;
  assign TIMEOUT_ERR = r_timeout_err;

endmodule
